button_request_encoder: RTL and testbench

- Front end that produces the elevator controller's request-pulse inputs from raw panel switches.
- Covers 12 hall buttons and 9+9 internal buttons for two cars.
- Synchronises, debounces and edge-detects each switch, then issues one-cycle new-request pulses. Presses already latched by the controller are suppressed.
- Tracks each request until the controller's current-button echo acknowledges it, and drives the panel lamps.

---
 rtl/button_request_encoder.sv | 125 ++++++++++++
 tb/tb_button_request_encoder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/button_request_encoder.sv
// Panel switch front end: synchronise, debounce and edge-detect 30 switches, issue
// one-cycle request pulses, and track each floor request until the controller echoes it.
module button_request_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned ACK_TIMEOUT     = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] rawRealFloorButton,
  input  logic [9:1]  rawInternalButton1,
  input  logic [9:1]  rawInternalButton2,
  input  logic [11:0] currentRealFloorButton,
  input  logic [9:1]  currentInternalButton1,
  input  logic [9:1]  currentInternalButton2,
  output logic [11:0] newRealFloorButton,
  output logic [9:1]  newInternalButton1,
  output logic [9:1]  newInternalButton2,
  output logic [11:0] lampRealFloorButton,
  output logic [9:1]  lampInternalButton1,
  output logic [9:1]  lampInternalButton2
);

  localparam int unsigned NCH = 30;
  localparam int unsigned CW  = 8;
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST = CW'(ACK_TIMEOUT - 1);
  // Channel order: hall [11:0], car1 [9:1] -> 20:12, car2 [9:1] -> 29:21.
  // Door open/close buttons of both cars are untracked channels.
  localparam logic [NCH-1:0] DOOR_MASK = 30'h3018_0000;

  logic [NCH-1:0] raw, cur;
  logic [NCH-1:0] s1, s2, stable, pending, pulse;
  logic [CW-1:0]  cnt   [NCH];
  logic [CW-1:0]  timer [NCH];

  logic [NCH-1:0] flip_c, press_c;
  logic [NCH-1:0] stable_n, pending_n, pulse_n;
  logic [CW-1:0]  cnt_n   [NCH];
  logic [CW-1:0]  timer_n [NCH];

  assign raw = {rawInternalButton2, rawInternalButton1, rawRealFloorButton};
  assign cur = {currentInternalButton2, currentInternalButton1, currentRealFloorButton};

  // A press is the edge on which the debounced state flips from 0 to 1.
  always_comb begin
    flip_c  = '0;
    press_c = '0;
    for (int i = 0; i < NCH; i++) begin
      flip_c[i]  = (s2[i] != stable[i]) && (cnt[i] == DB_LAST);
      press_c[i] = flip_c[i] && s2[i];
    end
  end

  // Per-channel debounce, pulse generation and pending/ack tracking.
  always_comb begin
    stable_n  = stable;
    pending_n = pending;
    pulse_n   = '0;
    for (int i = 0; i < NCH; i++) begin
      cnt_n[i]   = '0;
      timer_n[i] = timer[i];
    end
    for (int i = 0; i < NCH; i++) begin
      if (s2[i] != stable[i]) begin
        if (flip_c[i]) stable_n[i] = s2[i];
        else           cnt_n[i]    = cnt[i] + CW'(1);
      end

      if (DOOR_MASK[i]) begin
        pulse_n[i] = press_c[i];
      end else if (pending[i]) begin
        // Ack takes priority over timeout; a press while pending is absorbed.
        if (cur[i]) begin
          pending_n[i] = 1'b0;
          timer_n[i]   = '0;
        end else if (timer[i] == TO_LAST) begin
          timer_n[i] = '0;
          if (stable[i]) pulse_n[i]   = 1'b1;
          else           pending_n[i] = 1'b0;
        end else begin
          timer_n[i] = timer[i] + CW'(1);
        end
      end else if (press_c[i] && !cur[i]) begin
        pulse_n[i]   = 1'b1;
        pending_n[i] = 1'b1;
        timer_n[i]   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1      <= '0;
      s2      <= '0;
      stable  <= '0;
      pending <= '0;
      pulse   <= '0;
      for (int i = 0; i < NCH; i++) begin
        cnt[i]   <= '0;
        timer[i] <= '0;
      end
    end else begin
      s1      <= raw;
      s2      <= s1;
      stable  <= stable_n;
      pending <= pending_n;
      pulse   <= pulse_n;
      for (int i = 0; i < NCH; i++) begin
        cnt[i]   <= cnt_n[i];
        timer[i] <= timer_n[i];
      end
    end
  end

  logic [NCH-1:0] lamp_c;
  assign lamp_c = ((cur | pending) & ~DOOR_MASK) | (stable & DOOR_MASK);

  assign newRealFloorButton  = pulse[11:0];
  assign newInternalButton1  = pulse[20:12];
  assign newInternalButton2  = pulse[29:21];
  assign lampRealFloorButton = lamp_c[11:0];
  assign lampInternalButton1 = lamp_c[20:12];
  assign lampInternalButton2 = lamp_c[29:21];

endmodule

// File: tb/tb_button_request_encoder.sv
// Directed bench for button_request_encoder: a per-cycle vector table for the basic
// press/ack handshake plus hand-written multi-cycle sequences for the corner cases.
module tb_button_request_encoder;

  logic clk = 1'b0;
  logic reset;
  logic [29:0] raw_all, cur_all;

  logic [11:0] raw_h, cur_h, new_h, lamp_h;
  logic [9:1]  raw_1, raw_2, cur_1, cur_2, new_1, new_2, lamp_1, lamp_2;
  logic [29:0] new_all, lamp_all;

  assign raw_h = raw_all[11:0];
  assign raw_1 = raw_all[20:12];
  assign raw_2 = raw_all[29:21];
  assign cur_h = cur_all[11:0];
  assign cur_1 = cur_all[20:12];
  assign cur_2 = cur_all[29:21];
  assign new_all  = {new_2, new_1, new_h};
  assign lamp_all = {lamp_2, lamp_1, lamp_h};

  button_request_encoder dut (
    .clk                    (clk),
    .reset                  (reset),
    .rawRealFloorButton     (raw_h),
    .rawInternalButton1     (raw_1),
    .rawInternalButton2     (raw_2),
    .currentRealFloorButton (cur_h),
    .currentInternalButton1 (cur_1),
    .currentInternalButton2 (cur_2),
    .newRealFloorButton     (new_h),
    .newInternalButton1     (new_1),
    .newInternalButton2     (new_2),
    .lampRealFloorButton    (lamp_h),
    .lampInternalButton1    (lamp_1),
    .lampInternalButton2    (lamp_2)
  );

  always #5 clk = ~clk;

  // Bench channel positions: car1 [k] -> bit 11+k, car2 [k] -> bit 20+k.
  localparam logic [29:0] B_H3  = 30'd1 << 3;
  localparam logic [29:0] B_H0  = 30'd1 << 0;
  localparam logic [29:0] B_H11 = 30'd1 << 11;
  localparam logic [29:0] B_I1_1 = 30'd1 << 12;
  localparam logic [29:0] B_I1_4 = 30'd1 << 15;
  localparam logic [29:0] B_I1_5 = 30'd1 << 16;
  localparam logic [29:0] B_I1_8 = 30'd1 << 19;
  localparam logic [29:0] B_I2_2 = 30'd1 << 22;

  typedef struct {
    logic        rst;
    logic [29:0] raw;
    logic [29:0] cur;
    logic [29:0] exp_new;
    logic [29:0] exp_lamp;
  } vec_t;

  vec_t tbl [20];
  int n_vec  = 0;
  int n_miss = 0;

  function automatic vec_t mk(input logic r, input logic [29:0] rw, input logic [29:0] c,
                              input logic [29:0] en, input logic [29:0] el);
    vec_t v;
    v.rst = r; v.raw = rw; v.cur = c; v.exp_new = en; v.exp_lamp = el;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int cyc, input logic [29:0] en,
                       input logic [29:0] el);
    n_vec++;
    if (new_all !== en || lamp_all !== el) begin
      n_miss++;
      $display("FAIL %s cycle %0d: new=%h lamp=%h, expected new=%h lamp=%h",
               name, cyc, new_all, lamp_all, en, el);
    end
  endtask

  task automatic do_reset();
    raw_all = '0;
    cur_all = '0;
    reset   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("reset", i, '0, '0);
    end
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
    $fatal(1);
  end

  initial begin
    logic [29:0] en, el;

    // Basic press then ack handshake on hall bit 3.
    tbl[0] = mk(1'b0, '0, '0, '0, '0);
    tbl[1] = mk(1'b0, '0, '0, '0, '0);
    for (int i = 2; i <= 6; i++) tbl[i] = mk(1'b1, B_H3, '0, '0, '0);
    tbl[7] = mk(1'b1, B_H3, '0, B_H3, B_H3);
    tbl[8] = mk(1'b1, B_H3, '0, '0, B_H3);
    for (int i = 9; i <= 17; i++) tbl[i] = mk(1'b1, B_H3, B_H3, '0, B_H3);
    tbl[18] = mk(1'b1, B_H3, '0, '0, '0);
    tbl[19] = mk(1'b1, '0, '0, '0, '0);

    reset   = 1'b0;
    raw_all = '0;
    cur_all = '0;
    for (int i = 0; i < 20; i++) begin
      reset   = tbl[i].rst;
      raw_all = tbl[i].raw;
      cur_all = tbl[i].cur;
      tick();
      check("press_ack_table", i, tbl[i].exp_new, tbl[i].exp_lamp);
    end

    // Glitch of 3 cycles on car1 [5], then period-4 chatter.
    do_reset();
    for (int v = 0; v < 12; v++) begin
      raw_all = (v < 3) ? B_I1_5 : '0;
      tick();
      check("glitch", v, '0, '0);
    end
    for (int v = 0; v < 20; v++) begin
      raw_all = ((v % 4) < 2) ? B_I1_5 : '0;
      tick();
      check("chatter", v, '0, '0);
    end
    raw_all = '0;
    for (int v = 0; v < 6; v++) begin
      tick();
      check("chatter_tail", v, '0, '0);
    end

    // Held car2 [2] with no ack: re-pulse every 8 cycles.
    do_reset();
    raw_all = B_I2_2;
    for (int v = 0; v < 30; v++) begin
      tick();
      en = (v == 5 || v == 13 || v == 21 || v == 29) ? B_I2_2 : '0;
      el = (v >= 5) ? B_I2_2 : '0;
      check("timeout_held", v, en, el);
    end

    // Released before timeout: no re-pulse, lamp drops after the timeout edge.
    do_reset();
    for (int v = 0; v < 20; v++) begin
      raw_all = (v < 6) ? (B_H0 | B_I1_1) : '0;
      tick();
      en = (v == 5) ? (B_H0 | B_I1_1) : '0;
      el = (v >= 5 && v < 13) ? (B_H0 | B_I1_1) : '0;
      check("timeout_released", v, en, el);
    end

    // Press suppressed by an already-latched current bit.
    do_reset();
    cur_all = B_I1_4;
    raw_all = B_I1_4;
    for (int v = 0; v < 13; v++) begin
      if (v == 10) cur_all = '0;
      tick();
      check("suppressed", v, '0, (v < 10) ? B_I1_4 : '0);
    end

    // Door-open button pulses despite current, lamp follows the debounced state.
    do_reset();
    cur_all = B_I1_8;
    for (int v = 0; v < 17; v++) begin
      raw_all = (v < 8) ? B_I1_8 : '0;
      tick();
      en = (v == 5) ? B_I1_8 : '0;
      el = (v >= 5 && v < 13) ? B_I1_8 : '0;
      check("door", v, en, el);
    end

    // Reset while hall bit 11 is pending; held switch re-debounces after release.
    do_reset();
    raw_all = B_H11;
    for (int v = 0; v < 9; v++) begin
      tick();
      check("rst_mid_pre", v, (v == 5) ? B_H11 : '0, (v >= 5) ? B_H11 : '0);
    end
    reset = 1'b0;
    tick();
    check("rst_mid_clear", 9, '0, '0);
    reset = 1'b1;
    for (int v = 0; v < 13; v++) begin
      tick();
      check("rst_mid_post", v, (v == 5) ? B_H11 : '0, (v >= 5) ? B_H11 : '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
